// File: rtl/aexm_regf_gen.sv
// Parametrised aexm register file: three registered read ports with write-first
// bypass, load/store sizing, and a post-reset clearing sweep.
module aexm_regf_gen #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int SIGNEXT_EN = 1,
    parameter int INIT_SWEEP = 1
) (
    input  logic            gclk,
    input  logic            grst,
    input  logic            d_en,
    input  logic            x_en,
    input  logic [AW-1:0]   ra_addr,
    input  logic [AW-1:0]   rb_addr,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   xREGA,
    output logic [DW-1:0]   xREGB,
    input  logic [AW-1:0]   wb_addr,
    input  logic [1:0]      wb_sel,
    input  logic [DW-1:0]   wb_result,
    input  logic [DW-3:0]   wb_pc,
    input  logic [DW-1:0]   ld_data,
    input  logic [DW/8-1:0] ld_bsel,
    input  logic            ld_signed,
    input  logic [1:0]      st_size,
    output logic [DW-1:0]   st_data,
    output logic            ld_err,
    output logic            init_busy
);
    localparam int NL   = DW / 8;
    localparam int NREG = 2 ** AW;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt;
    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] rLD, rD, sized, shifted, wdata;
    logic [NL-1:0] rSEL;
    logic          we, sbit, fill, found;
    int unsigned   nb, lo;

    // Byte count of a legal lane pattern, 0 when the pattern is illegal.
    function automatic int unsigned sel_bytes(input logic [NL-1:0] s);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < NL; i++)
            if (s == (NL'(1) << i)) n = 1;
        for (int unsigned i = 0; i < NL; i += 2)
            if (s == (NL'(3) << i)) n = 2;
        for (int unsigned i = 0; i < NL; i += 4)
            if (s == (NL'(15) << i)) n = 4;
        if (NL == 8 && s == '1) n = 8;
        return n;
    endfunction

    always_comb begin
        nb      = sel_bytes(rSEL);
        lo      = 0;
        found   = 1'b0;
        sbit    = 1'b0;
        sized   = '0;
        for (int unsigned i = 0; i < NL; i++) begin
            if (rSEL[i] && !found) begin
                lo    = i;
                found = 1'b1;
            end
        end
        shifted = rLD >> (8 * lo);
        for (int unsigned j = 0; j < DW; j++)
            if (nb != 0 && j == 8 * nb - 1) sbit = shifted[j];
        fill = ld_signed && (SIGNEXT_EN != 0) && sbit;
        for (int unsigned j = 0; j < DW; j++)
            sized[j] = (j < 8 * nb) ? shifted[j] : fill;
    end

    always_comb begin
        case (wb_sel)
            2'd0:    wdata = wb_result;
            2'd1:    wdata = sized;
            2'd2:    wdata = {wb_pc, 2'b00};
            default: wdata = '0;
        endcase
        we = (state == RUN) && x_en && (wb_sel != 2'd3) && (wb_addr != '0);
    end

    // Port read value including write-first bypass; R0 and CLEAR read as zero.
    function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] addr);
        if (state == CLEAR || addr == '0) return '0;
        if (we && addr == wb_addr)        return wdata;
        return regs[addr];
    endfunction

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && cnt == AW'(NREG - 1)) state_nxt = RUN;
        init_busy = (state == CLEAR);
    end

    always_ff @(posedge gclk) begin
        if (state == CLEAR) regs[cnt]     <= '0;
        else if (we)        regs[wb_addr] <= wdata;
    end

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            state  <= (INIT_SWEEP != 0) ? CLEAR : RUN;
            cnt    <= '0;
            xREGA  <= '0;
            xREGB  <= '0;
            rD     <= '0;
            rLD    <= '0;
            rSEL   <= '0;
            ld_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            if (state == CLEAR) cnt <= cnt + AW'(1);
            rLD    <= ld_data;
            rSEL   <= ld_bsel;
            // Registered alongside rSEL so it flags exactly the cycle rSEL is sized.
            ld_err <= (sel_bytes(ld_bsel) == 0);
            if (d_en) begin
                xREGA <= rd_port(ra_addr);
                xREGB <= rd_port(rb_addr);
                rD    <= rd_port(rd_addr);
            end
        end
    end

    always_comb begin
        case (st_size)
            2'd0:    st_data = {NL{rD[7:0]}};
            2'd1:    st_data = {(NL/2){rD[15:0]}};
            2'd2:    st_data = {(DW/32){rD[31:0]}};
            default: st_data = (DW == 64) ? rD : {(DW/32){rD[31:0]}};
        endcase
    end
endmodule

// File: tb/tb_aexm_regf_gen.sv
// Self-checking bench for aexm_regf_gen: one 32-bit and one 64-bit instance
// sharing clock, reset and address inputs.
module tb_aexm_regf_gen;
    logic        gclk, grst, d_en, ld_signed;
    logic [4:0]  ra_addr, rb_addr, rd_addr, wb_addr;
    logic [1:0]  wb_sel, st_size;
    logic        x_en32, x_en64;
    logic [31:0] a32, b32, st32, res32, ldd32;
    logic [29:0] pc32;
    logic [3:0]  bsel32;
    logic        err32, busy32;
    logic [63:0] a64, b64, st64, res64, ldd64;
    logic [61:0] pc64;
    logic [7:0]  bsel64;
    logic        err64, busy64;

    int errors = 0;
    int checks = 0;

    aexm_regf_gen #(.DW(32), .AW(5), .SIGNEXT_EN(1), .INIT_SWEEP(1)) u32 (
        .gclk(gclk), .grst(grst), .d_en(d_en), .x_en(x_en32),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_addr(rd_addr),
        .xREGA(a32), .xREGB(b32), .wb_addr(wb_addr), .wb_sel(wb_sel),
        .wb_result(res32), .wb_pc(pc32), .ld_data(ldd32), .ld_bsel(bsel32),
        .ld_signed(ld_signed), .st_size(st_size), .st_data(st32),
        .ld_err(err32), .init_busy(busy32));

    aexm_regf_gen #(.DW(64), .AW(5), .SIGNEXT_EN(1), .INIT_SWEEP(1)) u64 (
        .gclk(gclk), .grst(grst), .d_en(d_en), .x_en(x_en64),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_addr(rd_addr),
        .xREGA(a64), .xREGB(b64), .wb_addr(wb_addr), .wb_sel(wb_sel),
        .wb_result(res64), .wb_pc(pc64), .ld_data(ldd64), .ld_bsel(bsel64),
        .ld_signed(ld_signed), .st_size(st_size), .st_data(st64),
        .ld_err(err64), .init_busy(busy64));

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef enum int unsigned {P_A32, P_B32, P_ST32, P_ERR32, P_A64, P_ST64, P_ERR64} port_t;
    typedef struct { string name; port_t port; logic [63:0] exp; } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        wide;
        logic [7:0]  bsel;
        logic        sgn;
        logic [63:0] data;
        logic [63:0] res;
        logic        err;
    } ld_vec_t;
    ld_vec_t vecs[21];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] actual(input port_t p);
        case (p)
            P_A32:   return 64'(a32);
            P_B32:   return 64'(b32);
            P_ST32:  return 64'(st32);
            P_ERR32: return 64'(err32);
            P_A64:   return a64;
            P_ST64:  return st64;
            default: return 64'(err64);
        endcase
    endfunction

    task automatic push(input string n, input port_t p, input logic [63:0] e);
        sb_t item;
        item.name = n; item.port = p; item.exp = e;
        sb_q.push_back(item);
    endtask

    task automatic drain();
        sb_t item;
        while (sb_q.size() > 0) begin
            item = sb_q.pop_front();
            check(item.name, actual(item.port), item.exp);
        end
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    // Counts cycles until init_busy drops, optionally issuing writes that must be ignored.
    task automatic count_sweep(input bit try_writes, output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            x_en32 = try_writes && (i < 20);
            x_en64 = 1'b0;
            wb_sel = 2'd0; wb_addr = 5'd9; res32 = 32'hFFFF_FFFF;
            d_en = 1'b1; ra_addr = 5'd9;
            tick();
            n++;
            if (try_writes && i == 5) check("clear_read_zero", 64'(a32), 64'd0);
            if (!busy32) break;
        end
        x_en32 = 1'b0;
    endtask

    logic [63:0] st_exp32[4];
    logic [63:0] st_exp64[4];
    int n;

    initial begin
        vecs = '{
            '{1'b0, 8'h8, 1'b1, 64'h80F17F02, 64'hFFFFFF80, 1'b0},
            '{1'b0, 8'h8, 1'b0, 64'h80F17F02, 64'h00000080, 1'b0},
            '{1'b0, 8'h3, 1'b1, 64'h80F17F02, 64'h00007F02, 1'b0},
            '{1'b0, 8'h6, 1'b1, 64'h80F17F02, 64'h00000000, 1'b1},
            '{1'b0, 8'h4, 1'b1, 64'h80F17F02, 64'hFFFFFFF1, 1'b0},
            '{1'b0, 8'hC, 1'b1, 64'h80F17F02, 64'hFFFF80F1, 1'b0},
            '{1'b0, 8'hC, 1'b0, 64'h80F17F02, 64'h000080F1, 1'b0},
            '{1'b0, 8'hF, 1'b1, 64'h80F17F02, 64'h80F17F02, 1'b0},
            '{1'b0, 8'h1, 1'b1, 64'h80F17F02, 64'h00000002, 1'b0},
            '{1'b0, 8'h2, 1'b1, 64'h80F17F02, 64'h0000007F, 1'b0},
            '{1'b0, 8'h0, 1'b1, 64'h80F17F02, 64'h00000000, 1'b1},
            '{1'b0, 8'h5, 1'b0, 64'h80F17F02, 64'h00000000, 1'b1},
            '{1'b0, 8'h3, 1'b1, 64'h00008000, 64'hFFFF8000, 1'b0},
            '{1'b1, 8'hF0, 1'b1, 64'h80000001_00000002, 64'hFFFFFFFF_80000001, 1'b0},
            '{1'b1, 8'hF0, 1'b0, 64'h80000001_00000002, 64'h00000000_80000001, 1'b0},
            '{1'b1, 8'hFF, 1'b1, 64'h80000001_00000002, 64'h80000001_00000002, 1'b0},
            '{1'b1, 8'h0F, 1'b1, 64'h80000001_00000002, 64'h00000000_00000002, 1'b0},
            '{1'b1, 8'hC0, 1'b1, 64'h80000001_00000002, 64'hFFFFFFFF_FFFF8000, 1'b0},
            '{1'b1, 8'h10, 1'b1, 64'h80000001_00000002, 64'h00000000_00000001, 1'b0},
            '{1'b1, 8'h3C, 1'b1, 64'h80000001_00000002, 64'h0, 1'b1},
            '{1'b1, 8'h80, 1'b0, 64'h80000001_00000002, 64'h00000000_00000080, 1'b0}
        };
        st_exp32 = '{64'h78787878, 64'h56785678, 64'h12345678, 64'h12345678};
        st_exp64 = '{64'h0D0D0D0D_0D0D0D0D, 64'hF00DF00D_F00DF00D,
                     64'hCAFEF00D_CAFEF00D, 64'h11223344_CAFEF00D};

        grst = 1'b0; d_en = 1'b0; ld_signed = 1'b0;
        ra_addr = '0; rb_addr = '0; rd_addr = '0; wb_addr = '0;
        wb_sel = 2'd3; st_size = 2'd0; x_en32 = 1'b0; x_en64 = 1'b0;
        res32 = '0; pc32 = '0; ldd32 = '0; bsel32 = 4'hF;
        res64 = '0; pc64 = '0; ldd64 = '0; bsel64 = 8'hFF;
        repeat (3) tick();
        check("rst_xrega", 64'(a32), 64'd0);
        check("rst_xregb", 64'(b32), 64'd0);
        check("rst_st_data", 64'(st32), 64'd0);
        check("rst_ld_err", 64'(err32), 64'd0);
        check("rst_busy", 64'(busy32), 64'd1);
        check("rst_busy64", 64'(busy64), 64'd1);

        grst = 1'b1;
        count_sweep(1'b1, n);
        check("sweep_len", 64'(n), 64'd32);
        check("sweep_done64", 64'(busy64), 64'd0);
        for (int i = 1; i < 32; i++) begin
            ra_addr = 5'(i); rb_addr = 5'(32 - i); d_en = 1'b1;
            push($sformatf("zero_a_r%0d", i), P_A32, 64'd0);
            push($sformatf("zero_b_r%0d", 32 - i), P_B32, 64'd0);
            tick();
            drain();
        end

        // Bypass, plain read, R0, wb_sel=3, link and x_en=0 writes.
        wb_sel = 2'd0; wb_addr = 5'd5; res32 = 32'hDEADBEEF; x_en32 = 1'b1;
        ra_addr = 5'd5; rb_addr = 5'd0;
        push("bypass_a", P_A32, 64'hDEADBEEF);
        push("bypass_b_r0", P_B32, 64'd0);
        tick(); drain();
        x_en32 = 1'b0;
        push("read_r5", P_A32, 64'hDEADBEEF);
        tick(); drain();
        wb_addr = 5'd0; res32 = 32'h1234; x_en32 = 1'b1; ra_addr = 5'd0;
        push("r0_write_bypass", P_A32, 64'd0);
        tick(); drain();
        x_en32 = 1'b0;
        push("r0_read", P_A32, 64'd0);
        tick(); drain();
        wb_sel = 2'd3; wb_addr = 5'd6; x_en32 = 1'b1; ra_addr = 5'd6;
        push("nowrite_sel3", P_A32, 64'd0);
        tick(); drain();
        wb_sel = 2'd2; pc32 = 30'h1234567; rb_addr = 5'd6;
        push("link_bypass", P_B32, 64'h048D159C);
        tick(); drain();
        x_en32 = 1'b0; wb_sel = 2'd0; wb_addr = 5'd8; res32 = 32'h5555; ra_addr = 5'd8;
        push("x_en_low_nowrite", P_A32, 64'd0);
        tick(); drain();

        for (int k = 0; k < 21; k++) begin
            ld_signed = vecs[k].sgn; wb_sel = 2'd3;
            if (vecs[k].wide) begin
                ldd64 = vecs[k].data; bsel64 = vecs[k].bsel;
            end else begin
                ldd32 = vecs[k].data[31:0]; bsel32 = vecs[k].bsel[3:0];
            end
            tick();
            push($sformatf("ld_err_v%0d", k), vecs[k].wide ? P_ERR64 : P_ERR32, 64'(vecs[k].err));
            drain();
            wb_sel = 2'd1; wb_addr = 5'd3; ra_addr = 5'd3; d_en = 1'b1;
            x_en32 = !vecs[k].wide; x_en64 = vecs[k].wide;
            push($sformatf("ld_bypass_v%0d", k), vecs[k].wide ? P_A64 : P_A32, vecs[k].res);
            tick(); drain();
            x_en32 = 1'b0; x_en64 = 1'b0; wb_sel = 2'd3;
            push($sformatf("ld_read_v%0d", k), vecs[k].wide ? P_A64 : P_A32, vecs[k].res);
            tick(); drain();
        end
        bsel32 = 4'hF; bsel64 = 8'hFF;

        wb_sel = 2'd0; wb_addr = 5'd7; res32 = 32'h12345678; x_en32 = 1'b1;
        rd_addr = 5'd7; d_en = 1'b1;
        tick();
        x_en32 = 1'b0;
        for (int s = 0; s < 4; s++) begin
            st_size = 2'(s); #1;
            push($sformatf("st32_size%0d", s), P_ST32, st_exp32[s]);
            drain();
        end
        wb_addr = 5'd4; res64 = 64'h11223344_CAFEF00D; x_en64 = 1'b1; rd_addr = 5'd4;
        tick();
        x_en64 = 1'b0;
        for (int s = 0; s < 4; s++) begin
            st_size = 2'(s); #1;
            push($sformatf("st64_size%0d", s), P_ST64, st_exp64[s]);
            drain();
        end

        // d_en low: ports hold while writes still land.
        wb_sel = 2'd0; wb_addr = 5'd20; res32 = 32'hA5A50014; x_en32 = 1'b1;
        tick();
        ra_addr = 5'd5; rb_addr = 5'd6; rd_addr = 5'd7; x_en32 = 1'b0; d_en = 1'b1;
        tick();
        d_en = 1'b0; ra_addr = 5'd20; rb_addr = 5'd20;
        for (int c = 0; c < 3; c++) begin
            wb_addr = 5'(21 + c); res32 = 32'(33 + c); x_en32 = 1'b1;
            push($sformatf("hold_a_c%0d", c), P_A32, 64'hDEADBEEF);
            push($sformatf("hold_b_c%0d", c), P_B32, 64'h048D159C);
            tick(); drain();
        end
        x_en32 = 1'b0; d_en = 1'b1; ra_addr = 5'd21; rb_addr = 5'd23;
        push("hold_write_r21", P_A32, 64'd33);
        push("hold_write_r23", P_B32, 64'd35);
        tick(); drain();
        ra_addr = 5'd22; rb_addr = 5'd20;
        push("hold_write_r22", P_A32, 64'd34);
        push("read_r20", P_B32, 64'hA5A50014);
        tick(); drain();

        // Asynchronous reset, then a second reset ten cycles into the sweep.
        d_en = 1'b0; st_size = 2'd2;
        #2 grst = 1'b0;
        #1;
        check("async_rst_xrega", 64'(a32), 64'd0);
        check("async_rst_st_data", 64'(st32), 64'd0);
        check("async_rst_busy", 64'(busy32), 64'd1);
        tick();
        grst = 1'b1;
        repeat (10) tick();
        check("mid_sweep_busy", 64'(busy32), 64'd1);
        #2 grst = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy32), 64'd1);
        tick();
        grst = 1'b1;
        count_sweep(1'b0, n);
        check("restart_sweep_len", 64'(n), 64'd32);
        d_en = 1'b1; ra_addr = 5'd20; rb_addr = 5'd7;
        push("swept_r20", P_A32, 64'd0);
        push("swept_r7", P_B32, 64'd0);
        tick(); drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
